// File: rtl/riscv_pkg.sv
// Types and constants shared by the RV32I program-counter sequencer.
package riscv_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        TRAP  = 2'd3
    } pc_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry buffer holding a branch redirect that could not be taken in the cycle it arrived.
module pc_redirect_buf
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        overwrite_i,
    input  logic        clear_i,
    input  logic [31:0] target_i,
    output logic        valid_o,
    output logic [31:0] target_o
);

    logic        valid_q, valid_d;
    logic [31:0] target_q, target_d;

    // clear wins: a consumed redirect must never survive into the next fetch
    always_comb begin
        valid_d  = valid_q;
        target_d = target_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if ((load_i && !valid_q) || (overwrite_i && valid_q)) begin
            valid_d  = 1'b1;
            target_d = target_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            target_q <= target_d;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = target_q;

endmodule

// File: rtl/pc_sequencer.sv
// PC register, fetch-request FSM and next-PC selection for the single-cycle RV32I datapath.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        misaligned
);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic        pend_valid;
    logic [31:0] pend_target;

    logic        advance;
    logic        branch_ok;
    logic        redirect;
    logic [31:0] target_sel;
    logic [31:0] next_pc;
    logic        target_bad;
    logic        capture;

    assign pc_plus4 = pc_q + PC_STEP;

    // HOLD exits through the same advance path so a buffered redirect is honoured there too
    assign advance    = ((state_q == FETCH) && imem_ready && !stall) ||
                        ((state_q == HOLD) && !stall);
    assign branch_ok  = branch_taken && ((state_q == FETCH) || (state_q == HOLD));
    assign redirect   = pend_valid || branch_ok;
    assign target_sel = pend_valid ? pend_target : branch_target;
    assign next_pc    = redirect ? target_sel : pc_plus4;
    assign target_bad = redirect && (target_sel[1:0] != 2'b00);
    assign capture    = branch_ok && !advance;

    pc_redirect_buf u_redirect_buf (
        .clk_i       (clock),
        .rst_i       (reset),
        .load_i      (capture),
        .overwrite_i (capture),
        .clear_i     (advance),
        .target_i    (branch_target),
        .valid_o     (pend_valid),
        .target_o    (pend_target)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH, HOLD: begin
                if (advance) begin
                    if (target_bad) begin
                        state_d = TRAP;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end else if ((state_q == FETCH) && imem_ready && stall) begin
                    state_d = HOLD;
                end
            end
            TRAP: begin
                pc_d    = TRAP_VECTOR;
                state_d = FETCH;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc         = pc_q;
    assign imem_req   = (state_q == FETCH);
    assign misaligned = (state_q == TRAP);

endmodule
